// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by the top level and by the tie-break picker.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   // Wide enough for the largest legal memory latency (15).
   localparam int CNT_W = $clog2(16);

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-input picker: round-robin or fixed CPU priority on ties.
// Holds the id of the requester granted most recently.
module arb_rr2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       fixed_prio,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = 2'b00;
         if (fixed_prio || (last == REQ_DMA)) begin
            gnt[REQ_CPU] = 1'b1;
         end else begin
            gnt[REQ_DMA] = 1'b1;
         end
      end
   end

   // Reset value makes the CPU win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= REQ_DMA;
      end else if (advance && (|gnt)) begin
         last <= gnt[REQ_DMA] ? REQ_DMA : REQ_CPU;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between the CPU memory stage and a DMA port,
// one transaction at a time with a fixed memory latency.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW         = 64,
   parameter int DW         = 64,
   parameter int MEM_LAT    = 1,
   parameter int FIXED_PRIO = 0
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             lat_we;
   logic             lat_owner;
   logic [AW-1:0]    lat_addr;
   logic [DW-1:0]    lat_wdata;
   logic [DW-1:0]    cpu_rdata_q;
   logic [DW-1:0]    dma_rdata_q;
   logic             idle;
   logic [1:0]       req;
   logic [1:0]       gnt;

   assign idle = (state == IDLE);

   // Requests are only visible to the picker in IDLE, so grants cannot occur elsewhere.
   assign req = idle ? {dma_req, cpu_req} : 2'b00;

   arb_rr2 u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .fixed_prio (FIXED_PRIO != 0),
      .advance    (idle),
      .gnt        (gnt)
   );

   assign cpu_gnt   = gnt[REQ_CPU];
   assign dma_gnt   = gnt[REQ_DMA];
   assign busy      = !idle;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      cpu_rvalid = 1'b0;
      dma_rvalid = 1'b0;
      case (state)
         IDLE: begin
            if (|gnt) state_nx = ISSUE;
         end
         ISSUE: begin
            mem_read  = !lat_we;
            mem_write = lat_we;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            state_nx  = WAIT;
         end
         WAIT: begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            if (cnt == '0) state_nx = RESP;
         end
         RESP: begin
            cpu_rvalid = (lat_owner == REQ_CPU);
            dma_rvalid = (lat_owner == REQ_DMA);
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we      <= 1'b0;
         lat_owner   <= REQ_CPU;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         cnt         <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         if (idle && (|gnt)) begin
            lat_owner <= gnt[REQ_DMA] ? REQ_DMA : REQ_CPU;
            lat_we    <= gnt[REQ_DMA] ? dma_we    : cpu_we;
            lat_addr  <= gnt[REQ_DMA] ? dma_addr  : cpu_addr;
            lat_wdata <= gnt[REQ_DMA] ? dma_wdata : cpu_wdata;
         end
         if (state == ISSUE) begin
            cnt <= CNT_W'(MEM_LAT - 1);
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
         // Read data is valid on the last WAIT cycle; writes leave rdata untouched.
         if ((state == WAIT) && (cnt == '0) && !lat_we) begin
            if (lat_owner == REQ_DMA) begin
               dma_rdata_q <= mem_rdata;
            end else begin
               cpu_rdata_q <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=1 round-robin, MEM_LAT=3 fixed priority)
// driven by shared stimulus and checked against a transaction-timeline model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [63:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

   logic        cpu_gnt [2];
   logic        dma_gnt [2];
   logic        cpu_rvalid [2];
   logic        dma_rvalid [2];
   logic        mem_read [2];
   logic        mem_write [2];
   logic        busy [2];
   logic [63:0] cpu_rdata [2];
   logic [63:0] dma_rdata [2];
   logic [63:0] mem_addr [2];
   logic [63:0] mem_wdata [2];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          rand_rdata = 1'b0;

   int          lat_m [2];
   int          prio_m [2];
   int          start_m [2];
   logic        we_m [2];
   logic        own_m [2];
   logic        last_m [2];
   logic [63:0] addr_m [2];
   logic [63:0] wdata_m [2];
   logic [63:0] rd_m [2][2];

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(64), .DW(64), .MEM_LAT(1), .FIXED_PRIO(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt[0]), .dma_rvalid(dma_rvalid[0]), .dma_rdata(dma_rdata[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata), .busy(busy[0])
   );

   dmem_arbiter #(.AW(64), .DW(64), .MEM_LAT(3), .FIXED_PRIO(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt[1]), .dma_rvalid(dma_rvalid[1]), .dma_rdata(dma_rdata[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata), .busy(busy[1])
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         start_m[i]  = -1;
         last_m[i]   = 1'b1;
         we_m[i]     = 1'b0;
         own_m[i]    = 1'b0;
         addr_m[i]   = '0;
         wdata_m[i]  = '0;
         rd_m[i][0]  = '0;
         rd_m[i][1]  = '0;
      end
   endtask

   // A transaction granted in cycle s occupies s+1 (strobe) .. s+L+2 (response).
   task automatic eval_cycle();
      int   d;
      logic act, e_cg, e_dg;
      for (int i = 0; i < 2; i++) begin
         d    = cyc - start_m[i];
         act  = (start_m[i] >= 0) && (d >= 1) && (d <= lat_m[i] + 2);
         e_cg = 1'b0;
         e_dg = 1'b0;
         if (!act) begin
            if (cpu_req && dma_req) begin
               if ((prio_m[i] != 0) || last_m[i]) e_cg = 1'b1;
               else                               e_dg = 1'b1;
            end else begin
               e_cg = cpu_req;
               e_dg = dma_req;
            end
         end
         chk($sformatf("i%0d busy", i),       64'(busy[i]),       64'(act));
         chk($sformatf("i%0d cpu_gnt", i),    64'(cpu_gnt[i]),    64'(e_cg));
         chk($sformatf("i%0d dma_gnt", i),    64'(dma_gnt[i]),    64'(e_dg));
         chk($sformatf("i%0d mem_read", i),   64'(mem_read[i]),   64'(act && d == 1 && !we_m[i]));
         chk($sformatf("i%0d mem_write", i),  64'(mem_write[i]),  64'(act && d == 1 && we_m[i]));
         chk($sformatf("i%0d mem_addr", i),   mem_addr[i],
             (act && d <= lat_m[i] + 1) ? addr_m[i] : 64'd0);
         chk($sformatf("i%0d mem_wdata", i),  mem_wdata[i],
             (act && d <= lat_m[i] + 1) ? wdata_m[i] : 64'd0);
         chk($sformatf("i%0d cpu_rvalid", i), 64'(cpu_rvalid[i]), 64'(act && d == lat_m[i] + 2 && !own_m[i]));
         chk($sformatf("i%0d dma_rvalid", i), 64'(dma_rvalid[i]), 64'(act && d == lat_m[i] + 2 && own_m[i]));
         chk($sformatf("i%0d cpu_rdata", i),  cpu_rdata[i],       rd_m[i][0]);
         chk($sformatf("i%0d dma_rdata", i),  dma_rdata[i],       rd_m[i][1]);
         if (act && d == lat_m[i] + 1 && !we_m[i]) rd_m[i][own_m[i]] = mem_rdata;
         if (e_cg || e_dg) begin
            start_m[i] = cyc;
            own_m[i]   = e_dg;
            last_m[i]  = e_dg;
            we_m[i]    = e_dg ? dma_we    : cpu_we;
            addr_m[i]  = e_dg ? dma_addr  : cpu_addr;
            wdata_m[i] = e_dg ? dma_wdata : cpu_wdata;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      eval_cycle();
      cyc++;
      @(posedge clk);
      #1;
      if (rand_rdata) mem_rdata = {$urandom, $urandom};
   endtask

   // Called just after a rising edge; outputs must clear before the next edge.
   task automatic do_reset();
      cpu_req = 1'b0;
      dma_req = 1'b0;
      rst_n   = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("i%0d rst busy", i),       64'(busy[i]),       64'd0);
         chk($sformatf("i%0d rst cpu_gnt", i),    64'(cpu_gnt[i]),    64'd0);
         chk($sformatf("i%0d rst dma_gnt", i),    64'(dma_gnt[i]),    64'd0);
         chk($sformatf("i%0d rst mem_read", i),   64'(mem_read[i]),   64'd0);
         chk($sformatf("i%0d rst mem_write", i),  64'(mem_write[i]),  64'd0);
         chk($sformatf("i%0d rst mem_addr", i),   mem_addr[i],        64'd0);
         chk($sformatf("i%0d rst mem_wdata", i),  mem_wdata[i],       64'd0);
         chk($sformatf("i%0d rst cpu_rvalid", i), 64'(cpu_rvalid[i]), 64'd0);
         chk($sformatf("i%0d rst dma_rvalid", i), 64'(dma_rvalid[i]), 64'd0);
         chk($sformatf("i%0d rst cpu_rdata", i),  cpu_rdata[i],       64'd0);
         chk($sformatf("i%0d rst dma_rdata", i),  dma_rdata[i],       64'd0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_fields();
      cpu_we    = 1'($urandom_range(0, 1));
      dma_we    = 1'($urandom_range(0, 1));
      cpu_addr  = {$urandom, $urandom};
      dma_addr  = {$urandom, $urandom};
      cpu_wdata = {$urandom, $urandom};
      dma_wdata = {$urandom, $urandom};
   endtask

   initial begin
      bit found;
      lat_m[0]  = 1;
      prio_m[0] = 0;
      lat_m[1]  = 3;
      prio_m[1] = 1;
      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      dma_req   = 1'b0;
      mem_rdata = '0;
      rand_fields();
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // CPU read of 0x20 with a fixed memory value.
      mem_rdata = 64'hDEAD_BEEF;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 64'h20;
      step();
      cpu_req = 1'b0;
      repeat (7) step();

      // DMA write of 0x55 to 0x40.
      rand_rdata = 1'b1;
      dma_req    = 1'b1;
      dma_we     = 1'b1;
      dma_addr   = 64'h40;
      dma_wdata  = 64'h55;
      step();
      dma_req = 1'b0;
      repeat (7) step();

      // Both requesters held high.
      cpu_req = 1'b1;
      dma_req = 1'b1;
      for (int k = 0; k < 24; k++) begin
         rand_fields();
         step();
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;
      repeat (6) step();

      // CPU request arriving while a DMA transaction is in flight.
      rand_fields();
      dma_req = 1'b1;
      step();
      dma_req = 1'b0;
      repeat (2) step();
      cpu_req = 1'b1;
      repeat (8) step();
      cpu_req = 1'b0;
      repeat (6) step();

      // Random traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         rand_fields();
         cpu_req = ($urandom_range(0, 99) < 55);
         dma_req = ($urandom_range(0, 99) < 55);
         if ($urandom_range(0, 149) == 0) do_reset();
         else                             step();
      end

      // Reset while the MEM_LAT=3 instance waits on a CPU read.
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         rand_fields();
         cpu_req = 1'b1;
         cpu_we  = 1'b0;
         dma_req = 1'b0;
         step();
         cpu_req = 1'b0;
         if (start_m[1] >= 0 && (cyc - start_m[1]) >= 2 && (cyc - start_m[1]) <= 4 && !we_m[1])
            found = 1'b1;
      end
      chk("reset_in_wait_reached", 64'(found), 64'd1);
      do_reset();
      cpu_req = 1'b1;
      dma_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         rand_fields();
         step();
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;
      repeat (8) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
